// File: rtl/mu0_pkg.sv
// Shared definitions for the MU0 accumulator CPU: widths, opcodes and FSM states.
package mu0_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_STA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_JMP = 4'h4;
  localparam logic [3:0] OP_JGE = 4'h5;
  localparam logic [3:0] OP_JNE = 4'h6;
  localparam logic [3:0] OP_STP = 4'h7;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  // True for the opcodes whose result comes from the ALU and lands in ACC.
  function automatic logic is_alu_op(input logic [3:0] op);
    return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/mu0_alu.sv
// Combinational datapath for the ACC-writing instructions (LDA, ADD, SUB).
module mu0_alu
  import mu0_pkg::*;
(
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] operand,
  output logic [DATA_W-1:0] result
);

  // Modulo 2^16 arithmetic; no carry or flags are kept.
  always_comb begin
    result = acc;
    case (op)
      OP_LDA:  result = operand;
      OP_ADD:  result = acc + operand;
      OP_SUB:  result = acc - operand;
      default: result = acc;
    endcase
  end

endmodule

// File: rtl/mu0_cpu.sv
// MU0 accumulator CPU: two-cycle FETCH/EXEC machine with a HALT sink state.
module mu0_cpu
  import mu0_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 12'h000
) (
  input  logic              clk,
  input  logic              reset,
  output logic              memRW,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] writedata,
  input  logic [DATA_W-1:0] readdata,
  output logic              halted,
  output logic [DATA_W-1:0] acc_out,
  output logic [ADDR_W-1:0] pc_out
);

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] alu_result;
  logic [3:0]        opcode;
  logic [ADDR_W-1:0] operand;

  assign opcode  = ir[15:12];
  assign operand = ir[ADDR_W-1:0];

  mu0_alu u_alu (
    .op      (opcode),
    .acc     (acc),
    .operand (readdata),
    .result  (alu_result)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_FETCH;
      pc    <= RESET_PC;
      acc   <= '0;
      ir    <= '0;
    end else begin
      case (state)
        ST_FETCH: begin
          ir    <= readdata;
          pc    <= pc + 1'b1;
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          state <= ST_FETCH;
          if (is_alu_op(opcode)) begin
            acc <= alu_result;
          end else begin
            case (opcode)
              OP_STA: ;
              OP_JMP: pc <= operand;
              OP_JGE: if (!acc[DATA_W-1]) pc <= operand;
              OP_JNE: if (acc != '0) pc <= operand;
              default: state <= ST_HALT;
            endcase
          end
        end
        ST_HALT: state <= ST_HALT;
        default: state <= ST_FETCH;
      endcase
    end
  end

  // Reset masks the write strobe immediately so an interrupted STA never lands.
  assign memRW     = !reset && (state == ST_EXEC) && (opcode == OP_STA);
  assign address   = (!reset && state == ST_EXEC) ? operand : pc;
  assign writedata = acc;
  assign halted    = !reset && (state == ST_HALT);
  assign acc_out   = acc;
  assign pc_out    = pc;

endmodule

// File: tb/tb_mu0_cpu.sv
// Directed bench for mu0_cpu with a 4K-word memory model that updates readdata on negedge.
module tb_mu0_cpu;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memRW;
  logic [11:0] address;
  logic [15:0] writedata;
  logic [15:0] readdata = 16'h0000;
  logic        halted;
  logic [15:0] acc_out;
  logic [11:0] pc_out;

  logic [15:0] mem [0:4095];
  logic        ld_we = 1'b0;
  logic [11:0] ld_addr = 12'h000;
  logic [15:0] ld_data = 16'h0000;
  int          wr_count = 0;
  int          checks = 0;
  int          errors = 0;

  mu0_cpu #(.RESET_PC(12'h000)) dut (
    .clk       (clk),
    .reset     (reset),
    .memRW     (memRW),
    .address   (address),
    .writedata (writedata),
    .readdata  (readdata),
    .halted    (halted),
    .acc_out   (acc_out),
    .pc_out    (pc_out)
  );

  always #5 clk = ~clk;

  always @(negedge clk) readdata <= mem[address];

  always @(posedge clk) begin
    if (ld_we) begin
      mem[ld_addr] <= ld_data;
    end else if (memRW) begin
      mem[address] <= writedata;
      wr_count     <= wr_count + 1;
    end
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Loads go through the memory process while the CPU sits in reset.
  task automatic load(input logic [11:0] a, input logic [15:0] d);
    ld_we   = 1'b1;
    ld_addr = a;
    ld_data = d;
    tick(1);
    ld_we   = 1'b0;
    $display("load mem[%h] = %h", a, d);
  endtask

  int wr_base;

  initial begin
    // Reset state after two cycles.
    tick(2);
    check("rst_memRW", 16'(memRW), 16'h0);
    check("rst_addr", 16'(address), 16'h000);
    check("rst_acc", acc_out, 16'h0000);
    check("rst_pc", 16'(pc_out), 16'h000);
    check("rst_halted", 16'(halted), 16'h0);

    // LDA/ADD/STA/STP program.
    load(12'h000, 16'h0010);
    load(12'h001, 16'h2011);
    load(12'h002, 16'h1012);
    load(12'h003, 16'h7000);
    load(12'h010, 16'h0005);
    load(12'h011, 16'h0003);
    load(12'h012, 16'h0000);
    reset = 1'b0;
    tick(2);
    check("p1_acc_lda", acc_out, 16'h0005);
    tick(2);
    check("p1_acc_add", acc_out, 16'h0008);
    tick(1);
    check("p1_sta_memRW", 16'(memRW), 16'h1);
    check("p1_sta_addr", 16'(address), 16'h012);
    check("p1_sta_wdata", writedata, 16'h0008);
    tick(2);
    check("p1_halt_c7", 16'(halted), 16'h0);
    tick(1);
    check("p1_halt_c8", 16'(halted), 16'h1);
    check("p1_pc", 16'(pc_out), 16'h004);
    check("p1_mem012", mem[12'h012], 16'h0008);
    check("p1_halt_addr", 16'(address), 16'h004);
    $display("program1 done acc=%h pc=%h", acc_out, pc_out);

    // Reset exits HALT and masks halted immediately.
    reset = 1'b1;
    #1;
    check("halt_rst_comb", 16'(halted), 16'h0);

    // LDA 0, SUB 1 -> FFFF; JGE not taken, JNE taken.
    load(12'h000, 16'h0020);
    load(12'h001, 16'h3021);
    load(12'h002, 16'h5030);
    load(12'h003, 16'h6040);
    load(12'h020, 16'h0000);
    load(12'h021, 16'h0001);
    load(12'h030, 16'h7000);
    load(12'h040, 16'h7000);
    check("p2_rst_pc", 16'(pc_out), 16'h000);
    reset = 1'b0;
    tick(4);
    check("p2_acc_sub", acc_out, 16'hFFFF);
    tick(2);
    check("p2_jge_pc", 16'(pc_out), 16'h003);
    tick(2);
    check("p2_jne_pc", 16'(pc_out), 16'h040);
    tick(2);
    check("p2_halted", 16'(halted), 16'h1);
    check("p2_final_pc", 16'(pc_out), 16'h041);
    $display("program2 done acc=%h pc=%h", acc_out, pc_out);

    // PC wrap at FFF and a JMP self-loop with no writes.
    reset = 1'b1;
    load(12'h000, 16'h5FFF);
    load(12'h001, 16'h4005);
    load(12'h005, 16'h4005);
    load(12'h010, 16'h8000);
    load(12'hFFF, 16'h0010);
    wr_base = wr_count;
    reset = 1'b0;
    tick(2);
    check("p3_jmp_fff", 16'(pc_out), 16'hFFF);
    tick(1);
    check("p3_wrap", 16'(pc_out), 16'h000);
    tick(1);
    check("p3_acc", acc_out, 16'h8000);
    tick(6);
    check("p3_loop_a", 16'(pc_out), 16'h005);
    tick(2);
    check("p3_loop_b", 16'(pc_out), 16'h005);
    check("p3_no_halt", 16'(halted), 16'h0);
    check("p3_no_writes", 16'(wr_count - wr_base), 16'h0);
    $display("program3 done acc=%h pc=%h", acc_out, pc_out);

    // Reset during STA EXEC blocks the write.
    reset = 1'b1;
    load(12'h000, 16'h0010);
    load(12'h001, 16'h1020);
    load(12'h010, 16'hABCD);
    load(12'h020, 16'h5555);
    reset = 1'b0;
    tick(3);
    check("p4_sta_memRW", 16'(memRW), 16'h1);
    reset = 1'b1;
    #1;
    check("p4_rst_memRW", 16'(memRW), 16'h0);
    tick(1);
    check("p4_mem020", mem[12'h020], 16'h5555);
    check("p4_pc", 16'(pc_out), 16'h000);
    check("p4_acc", acc_out, 16'h0000);
    reset = 1'b0;
    tick(2);
    check("p4_restart_acc", acc_out, 16'hABCD);
    $display("program4 done acc=%h pc=%h", acc_out, pc_out);

    // Undefined opcode halts without touching ACC.
    reset = 1'b1;
    load(12'h000, 16'h0010);
    load(12'h001, 16'h8ABC);
    load(12'h010, 16'h1111);
    wr_base = wr_count;
    reset = 1'b0;
    tick(4);
    check("p5_halted", 16'(halted), 16'h1);
    check("p5_acc", acc_out, 16'h1111);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("p5_addr", 16'(address), 16'h002);
      check("p5_memRW", 16'(memRW), 16'h0);
    end
    check("p5_pc", 16'(pc_out), 16'h002);
    check("p5_no_writes", 16'(wr_count - wr_base), 16'h0);
    $display("program5 done acc=%h pc=%h", acc_out, pc_out);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
